// File: rtl/note_sequencer_pkg.sv
// Shared register map, CONTROL/status bit positions and FSM states.
package note_sequencer_pkg;

  localparam logic [1:0] ADDR_PERIOD   = 2'd0;
  localparam logic [1:0] ADDR_DURATION = 2'd1;
  localparam logic [1:0] ADDR_CONTROL  = 2'd2;

  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;

  localparam int unsigned ST_AUDIO     = 0;
  localparam int unsigned ST_PLAYING   = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_FULL      = 3;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_OVERFLOW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous note FIFO.
// Ports: push/pop/flush controls, din/dout data, full/empty/count status.
// Push while full is dropped; flush empties the FIFO and overrides push/pop.
module note_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/note_sequencer.sv
// Memory-mapped tone controller: queued (half-period, duration) notes are
// played back-to-back as a square wave.
// Ports: clock/reset, IO write port (wr_en, wr_addr, wr_data), audio_out,
// playing, fifo_full, fifo_empty, status word for the IO read mux.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PERIOD_W   = 20,
  parameter int unsigned DUR_W      = 12,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        audio_out,
  output logic        playing,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [31:0] status
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned EW = PERIOD_W + DUR_W;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t state, state_nx;

  logic [PERIOD_W-1:0] staging;
  logic [PERIOD_W-1:0] half_period, half_period_nx;
  logic [PERIOD_W-1:0] phase, phase_nx;
  logic [DUR_W-1:0]    remaining, remaining_nx;
  logic [PW-1:0]       presc, presc_nx;
  logic                audio_nx;
  logic                playing_nx;
  logic                overflow;

  logic          wr_period, wr_dur, wr_ctrl, flush, clr_ovf;
  logic          pop_head;
  logic [EW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic          unused_wr;

  assign wr_period = wr_en && (wr_addr == ADDR_PERIOD);
  assign wr_dur    = wr_en && (wr_addr == ADDR_DURATION);
  assign wr_ctrl   = wr_en && (wr_addr == ADDR_CONTROL);
  assign flush     = wr_ctrl && wr_data[CTRL_FLUSH];
  assign clr_ovf   = wr_ctrl && wr_data[CTRL_CLR_OVF];
  assign pop_head  = (state == IDLE) && !fifo_empty;
  assign unused_wr = ^wr_data;

  note_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_dur),
    .pop   (pop_head),
    .flush (flush),
    .din   ({staging, wr_data[DUR_W-1:0]}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The head is captured on the popping edge, so LOAD works from the
  // registered copy rather than re-reading the FIFO.
  always_comb begin
    state_nx       = state;
    half_period_nx = half_period;
    remaining_nx   = remaining;
    phase_nx       = phase;
    presc_nx       = presc;
    audio_nx       = audio_out;
    case (state)
      IDLE: begin
        audio_nx = 1'b0;
        if (pop_head) begin
          half_period_nx = fifo_head[EW-1:DUR_W];
          remaining_nx   = fifo_head[DUR_W-1:0];
          state_nx       = LOAD;
        end
      end
      LOAD: begin
        phase_nx = '0;
        presc_nx = '0;
        audio_nx = 1'b0;
        state_nx = (remaining == '0) ? IDLE : PLAY;
      end
      PLAY: begin
        if (half_period != '0) begin
          if (phase == half_period - 1'b1) begin
            audio_nx = ~audio_out;
            phase_nx = '0;
          end else begin
            phase_nx = phase + 1'b1;
          end
        end
        if (presc == PRESC_MAX) begin
          presc_nx = '0;
          if (remaining == DUR_W'(1)) begin
            audio_nx = 1'b0;
            state_nx = IDLE;
          end else begin
            remaining_nx = remaining - 1'b1;
          end
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      audio_nx = 1'b0;
    end
    playing_nx = (state_nx == LOAD) || (state_nx == PLAY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      staging     <= '0;
      half_period <= '0;
      remaining   <= '0;
      phase       <= '0;
      presc       <= '0;
      audio_out   <= 1'b0;
      playing     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      half_period <= half_period_nx;
      remaining   <= remaining_nx;
      phase       <= phase_nx;
      presc       <= presc_nx;
      audio_out   <= audio_nx;
      playing     <= playing_nx;
      if (wr_period) staging <= wr_data[PERIOD_W-1:0];
      if (wr_dur && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)        overflow <= 1'b0;
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_AUDIO]            = audio_out;
    status[ST_PLAYING]          = playing;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
    status[ST_OVERFLOW]         = overflow;
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int T     = 4;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        audio_out, playing, fifo_full, fifo_empty;
  logic [31:0] status;

  note_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .PERIOD_W   (20),
    .DUR_W      (12),
    .TICK_DIV   (T)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .audio_out  (audio_out),
    .playing    (playing),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .status     (status)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: notes are scheduled by arithmetic on edge numbers.
  // A note pushed at edge E is popped at max(E+1, previous pop + 2 + dur*T),
  // is "playing" from its pop edge through pop + dur*T.
  typedef struct { int hp; int dur; } note_t;
  note_t exp_q[$];
  int    pop_edge[$];
  int    pop_dur[$];
  int    e         = 0;
  int    acc       = 0;
  int    prev_free = 0;
  int    stage_m   = 0;
  bit    ovf_m     = 0;
  bit    model_on  = 0;
  bit    sb_en     = 0;

  function automatic int model_count(input int at);
    int n = acc;
    foreach (pop_edge[k]) if (pop_edge[k] <= at) n--;
    return n;
  endfunction

  function automatic bit model_playing(input int at);
    foreach (pop_edge[k])
      if (pop_edge[k] <= at && at <= pop_edge[k] + pop_dur[k] * T) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_audio(input int hp, input int idx);
    if (idx == 0 || hp == 0) return 1'b0;
    return logic'(((idx - 1) / hp) % 2);
  endfunction

  task automatic model_reset();
    pop_edge.delete();
    pop_dur.delete();
    exp_q.delete();
    acc       = 0;
    prev_free = 0;
  endtask

  // One clock: apply a write (or none) for the next edge, update the model,
  // then check the status view against the model after the edge.
  task automatic step(input bit en, input logic [1:0] a, input logic [31:0] d);
    int    cnt, pk;
    note_t n;
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
    if (model_on && en) begin
      if (a == 2'd0) begin
        stage_m = int'(d[19:0]);
      end else if (a == 2'd1) begin
        cnt = model_count(e);
        if (cnt == DEPTH) begin
          ovf_m = 1'b1;
        end else begin
          n.hp  = stage_m;
          n.dur = int'(d[11:0]);
          pk    = (e + 2 > prev_free) ? e + 2 : prev_free;
          pop_edge.push_back(pk);
          pop_dur.push_back(n.dur);
          prev_free = pk + 2 + n.dur * T;
          acc++;
          exp_q.push_back(n);
        end
      end else if (a == 2'd2 && d[1]) begin
        ovf_m = 1'b0;
      end
    end
    @(posedge clock);
    e++;
    #1;
    wr_en = 1'b0;
    if (model_on) begin
      cnt = model_count(e);
      check("count",      {28'd0, status[7:4]}, cnt);
      check("empty",      {31'd0, fifo_empty}, (cnt == 0) ? 1 : 0);
      check("full",       {31'd0, fifo_full},  (cnt == DEPTH) ? 1 : 0);
      check("overflow",   {31'd0, status[8]},  {31'd0, ovf_m});
      check("playing",    {31'd0, playing},    {31'd0, model_playing(e)});
      check("st_playing", {31'd0, status[1]},  {31'd0, model_playing(e)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 32'd0);
  endtask

  task automatic drain();
    while (e < prev_free + 1) step(1'b0, 2'd0, 32'd0);
    idle(2);
  endtask

  // Monitor: each run of playing=1 is one popped note (LOAD + PLAY cycles).
  bit    in_run = 0;
  int    idx    = 0;
  bit    wave_ok;
  note_t cur;

  initial begin
    forever begin
      @(negedge clock);
      if (!sb_en || reset) begin
        in_run = 0;
        continue;
      end
      if (playing) begin
        if (!in_run) begin
          in_run  = 1;
          idx     = 0;
          wave_ok = 1;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_note: got a note, expected none at %0t", $time);
            cur.hp  = 0;
            cur.dur = 0;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        if (audio_out !== exp_audio(cur.hp, idx)) wave_ok = 0;
        idx++;
      end else if (in_run) begin
        in_run = 0;
        check("note_len",   idx, 1 + cur.dur * T);
        check("note_wave",  {31'd0, wave_ok}, 1);
        check("gap_audio",  {31'd0, audio_out}, 0);
      end
    end
  end

  initial begin
    int r;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = 32'd0;
    #1;
    check("rst_status", status, 32'h4);
    check("rst_audio",  {31'd0, audio_out}, 0);
    check("rst_empty",  {31'd0, fifo_empty}, 1);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    e        = 0;
    model_on = 1;
    sb_en    = 1;

    // period 3, duration 2
    step(1, 2'd0, 32'd3);
    step(1, 2'd1, 32'd2);
    drain();

    // periods 2, 0, 5 with duration 1
    step(1, 2'd0, 32'd2);
    step(1, 2'd1, 32'd1);
    step(1, 2'd0, 32'd0);
    step(1, 2'd1, 32'd1);
    step(1, 2'd0, 32'd5);
    step(1, 2'd1, 32'd1);
    drain();

    // zero-duration entry then period 1, duration 1
    step(1, 2'd1, 32'd0);
    step(1, 2'd0, 32'd1);
    step(1, 2'd1, 32'd1);
    drain();

    // overflow with a long note keeping the sequencer busy
    step(1, 2'd0, 32'd6);
    step(1, 2'd1, 32'd3);
    idle(2);
    repeat (5) step(1, 2'd1, 32'd1);
    step(1, 2'd2, 32'd2);
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      step(1, 2'd0, ($urandom & 32'hFFF0_0000) | $urandom_range(0, 5));
      else if (r <= 5) step(1, 2'd1, ($urandom & 32'hFFFF_F000) | $urandom_range(0, 3));
      else if (r == 6) step(1, 2'd2, $urandom & 32'hFFFF_FFFE);
      else if (r == 7) step(1, 2'd3, $urandom);
      else             idle(1);
    end
    drain();
    check("queue_drained", exp_q.size(), 0);

    // flush during PLAY with two entries queued
    model_on = 0;
    sb_en    = 0;
    step(1, 2'd0, 32'd2);
    step(1, 2'd1, 32'd3);
    step(1, 2'd1, 32'd1);
    step(1, 2'd1, 32'd1);
    idle(3);
    check("pre_flush_count",   {28'd0, status[7:4]}, 2);
    check("pre_flush_playing", {31'd0, playing}, 1);
    step(1, 2'd2, 32'd1);
    check("flush_count",   {28'd0, status[7:4]}, 0);
    check("flush_playing", {31'd0, playing}, 0);
    check("flush_audio",   {31'd0, audio_out}, 0);
    check("flush_empty",   {31'd0, fifo_empty}, 1);
    model_reset();
    stage_m  = 2;
    model_on = 1;
    sb_en    = 1;
    step(1, 2'd1, 32'd1);
    drain();
    check("queue_drained2", exp_q.size(), 0);

    // asynchronous reset in the middle of a note
    model_on = 0;
    sb_en    = 0;
    step(1, 2'd0, 32'd1);
    step(1, 2'd1, 32'd3);
    idle(4);
    check("pre_rst_playing", {31'd0, playing}, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_audio",   {31'd0, audio_out}, 0);
    check("async_rst_playing", {31'd0, playing}, 0);
    check("async_rst_status",  status, 32'h4);
    #20 reset = 1'b0;
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
